mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 109 ++++++++++
 tb/tb_mem_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Main-memory model behind the L2: fixed-latency line read/write with a
// per-line valid bit, one request at a time, single-cycle completion pulse.
module mem_ctrl #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned AWIDTH  = 10
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         read_L2_MEM,
   input  logic         write_L2_MEM,
   input  logic [7:0]   index_L2_MEM,
   input  logic [17:0]  tag_L2_MEM,
   input  logic [17:0]  write_tag_L2_MEM,
   input  logic [511:0] write_data_L2_MEM,
   output logic         ready_MEM_L2,
   output logic [511:0] read_data_MEM_L2
);

   localparam int unsigned DEPTH = 1 << AWIDTH;
   localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY, RESP} state_t;

   state_t              state_q;
   logic [7:0]          cnt_q;
   logic                ready_q;
   logic                rd_pend_q;
   logic [511:0]        rdata_q;
   logic [511:0]        wdata_q;
   logic [AWIDTH-1:0]   rd_addr_q, wr_addr_q;
   logic [AWIDTH-1:0]   rd_addr_d, wr_addr_d;
   logic [DEPTH-1:0]    valid_q;
   logic                mem_we;
   logic [25:0]         rd_line, wr_line;

   logic [511:0]        mem [DEPTH];

   // Upper tag bits are dropped on purpose: lines alias modulo 2^AWIDTH.
   always_comb begin
      rd_line   = {tag_L2_MEM, index_L2_MEM};
      wr_line   = {write_tag_L2_MEM, index_L2_MEM};
      rd_addr_d = rd_line[AWIDTH-1:0];
      wr_addr_d = wr_line[AWIDTH-1:0];
      mem_we    = (state_q == WR_BUSY) && (cnt_q == '0);
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_addr_q] <= wdata_q;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ready_q   <= 1'b0;
         rd_pend_q <= 1'b0;
         rdata_q   <= '0;
         wdata_q   <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         valid_q   <= '0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (write_L2_MEM || read_L2_MEM) begin
                  rd_addr_q <= rd_addr_d;
                  wr_addr_q <= wr_addr_d;
                  wdata_q   <= write_data_L2_MEM;
                  cnt_q     <= CNT_LOAD;
                  rd_pend_q <= write_L2_MEM && read_L2_MEM;
                  state_q   <= write_L2_MEM ? WR_BUSY : RD_BUSY;
               end
            end
            WR_BUSY: begin
               if (cnt_q == '0) begin
                  valid_q[wr_addr_q] <= 1'b1;
                  if (rd_pend_q) begin
                     state_q <= RD_BUSY;
                     cnt_q   <= CNT_LOAD;
                  end else begin
                     state_q <= RESP;
                     ready_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            RD_BUSY: begin
               if (cnt_q == '0) begin
                  rdata_q <= valid_q[rd_addr_q] ? mem[rd_addr_q] : '0;
                  state_q <= RESP;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_MEM_L2     = ready_q;
   assign read_data_MEM_L2 = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a line-store model predicts pulse timing and
// fill data, checked every cycle, plus literal expectations per scenario.
module tb_mem_ctrl;

   localparam int L  = 4;
   localparam int AW = 10;

   logic         clk;
   logic         nrst;
   logic         read_L2_MEM, write_L2_MEM;
   logic [7:0]   index_L2_MEM;
   logic [17:0]  tag_L2_MEM, write_tag_L2_MEM;
   logic [511:0] write_data_L2_MEM;
   logic         ready_MEM_L2;
   logic [511:0] read_data_MEM_L2;

   mem_ctrl #(.LATENCY(L), .AWIDTH(AW)) dut (
      .clk               (clk),
      .nrst              (nrst),
      .read_L2_MEM       (read_L2_MEM),
      .write_L2_MEM      (write_L2_MEM),
      .index_L2_MEM      (index_L2_MEM),
      .tag_L2_MEM        (tag_L2_MEM),
      .write_tag_L2_MEM  (write_tag_L2_MEM),
      .write_data_L2_MEM (write_data_L2_MEM),
      .ready_MEM_L2      (ready_MEM_L2),
      .read_data_MEM_L2  (read_data_MEM_L2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int pcnt   = 0;

   // Model state: backing store of written lines, predicted pulse edge, fill data.
   logic [511:0] mdl [int];
   int           exp_at     = -1;
   bit           exp_is_rd  = 1'b0;
   logic [511:0] exp_rd_new = '0;
   logic [511:0] exp_rdata  = '0;

   always @(posedge clk) pcnt <= pcnt + 1;

   function automatic int line_of(input logic [17:0] t, input logic [7:0] i);
      return (int'(t) * 256 + int'(i)) % (1 << AW);
   endfunction

   task automatic chk_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at edge %0d: got %b want %b", name, pcnt, got, exp);
      end
   endtask

   task automatic chk_line(input string name, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at edge %0d: got %h want %h", name, pcnt, got, exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d want %0d", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!nrst) begin
         exp_rdata = '0;
         exp_at    = -1;
      end else if (pcnt == exp_at && exp_is_rd) begin
         exp_rdata = exp_rd_new;
      end
      chk_bit("ready", ready_MEM_L2, nrst && (pcnt == exp_at));
      chk_line("rdata", read_data_MEM_L2, exp_rdata);
   end

   task automatic run_op(input bit wr, input bit rd, input logic [17:0] wtag,
                         input logic [17:0] rtag, input logic [7:0] idx,
                         input logic [511:0] data, input bit hold,
                         output int lat, output int pulse, output logic [511:0] got);
      int acc;
      int waddr, raddr;
      bit seen;
      @(negedge clk);
      write_L2_MEM      = wr;
      read_L2_MEM       = rd;
      write_tag_L2_MEM  = wtag;
      tag_L2_MEM        = rtag;
      index_L2_MEM      = idx;
      write_data_L2_MEM = data;
      @(posedge clk);
      #1;
      acc   = pcnt;
      waddr = line_of(wtag, idx);
      raddr = line_of(rtag, idx);
      if (wr) mdl[waddr] = data;
      exp_is_rd  = rd;
      exp_rd_new = (rd && mdl.exists(raddr)) ? mdl[raddr] : '0;
      exp_at     = acc + ((wr && rd) ? 2 * L : L);
      // Perturb inputs after acceptance; the DUT must use the latched values.
      write_data_L2_MEM = ~data;
      write_tag_L2_MEM  = wtag ^ 18'h3;
      tag_L2_MEM        = rtag ^ 18'h3;
      index_L2_MEM      = idx ^ 8'hFF;
      seen = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (ready_MEM_L2) begin
            seen = 1'b1;
            break;
         end
      end
      pulse = pcnt;
      lat   = pulse - acc;
      got   = read_data_MEM_L2;
      if (!seen) begin
         checks++;
         fails++;
         $display("FAIL timeout: no ready within 600 cycles of edge %0d", acc);
      end
      if (!hold) begin
         write_L2_MEM = 1'b0;
         read_L2_MEM  = 1'b0;
      end
   endtask

   logic [511:0] pat_a, pat_b, pat_c, pat_d, got;
   int lat, p1, p2;

   initial begin
      pat_a = {16{32'hA5A5_0001}};
      pat_b = {16{32'h5A5A_0002}};
      pat_c = {8{64'hC0DE_1234_0003_FFFF}};
      pat_d = {16{32'hDEAD_0004}};
      nrst = 1'b0;
      read_L2_MEM = 1'b0;
      write_L2_MEM = 1'b0;
      index_L2_MEM = '0;
      tag_L2_MEM = '0;
      write_tag_L2_MEM = '0;
      write_data_L2_MEM = '0;
      repeat (3) @(negedge clk);
      #2 nrst = 1'b1;
      repeat (2) @(negedge clk);

      // Unwritten line reads zero.
      run_op(1'b0, 1'b1, 18'h0, 18'h0, 8'h05, '0, 1'b0, lat, p1, got);
      chk_int("lat_rd_cold", lat, 4);
      chk_line("data_rd_cold", got, 512'h0);

      // Write then read back.
      run_op(1'b1, 1'b0, 18'h1, 18'h0, 8'h10, pat_a, 1'b0, lat, p1, got);
      chk_int("lat_wr", lat, 4);
      chk_line("data_after_wr_only", got, 512'h0);
      run_op(1'b0, 1'b1, 18'h0, 18'h1, 8'h10, '0, 1'b0, lat, p1, got);
      chk_int("lat_rd_a", lat, 4);
      chk_line("data_rd_a", got, pat_a);

      // Combined write+read, same line: one pulse after 2*LATENCY.
      run_op(1'b1, 1'b1, 18'h2, 18'h2, 8'h03, pat_b, 1'b0, lat, p1, got);
      chk_int("lat_wr_rd", lat, 8);
      chk_line("data_wr_rd", got, pat_b);

      // Aliasing: tag 0x10 and tag 0 share the stored line at AWIDTH=10.
      run_op(1'b1, 1'b0, 18'h0, 18'h0, 8'h00, pat_c, 1'b0, lat, p1, got);
      run_op(1'b0, 1'b1, 18'h0, 18'h10, 8'h00, '0, 1'b0, lat, p1, got);
      chk_line("data_alias", got, pat_c);

      // Back-to-back reads with request held across the pulse.
      run_op(1'b0, 1'b1, 18'h0, 18'h1, 8'h10, '0, 1'b1, lat, p1, got);
      chk_line("data_b2b_1", got, pat_a);
      run_op(1'b0, 1'b1, 18'h0, 18'h1, 8'h10, '0, 1'b0, lat, p2, got);
      chk_line("data_b2b_2", got, pat_a);
      chk_int("b2b_spacing", p2 - p1, 6);

      repeat (3) @(negedge clk);

      // Reset two cycles into a write: no pulse, storage untouched, valids cleared.
      @(negedge clk);
      write_L2_MEM      = 1'b1;
      write_tag_L2_MEM  = 18'h7;
      index_L2_MEM      = 8'h21;
      write_data_L2_MEM = pat_d;
      @(posedge clk);
      #1;
      exp_at    = pcnt + L;
      exp_is_rd = 1'b0;
      repeat (2) @(negedge clk);
      #2 nrst = 1'b0;
      write_L2_MEM = 1'b0;
      exp_at = -1;
      mdl.delete();
      repeat (2) @(negedge clk);
      #2 nrst = 1'b1;
      repeat (4) @(negedge clk);
      run_op(1'b0, 1'b1, 18'h0, 18'h7, 8'h21, '0, 1'b0, lat, p1, got);
      chk_int("lat_after_rst", lat, 4);
      chk_line("data_after_rst", got, 512'h0);
      run_op(1'b0, 1'b1, 18'h0, 18'h1, 8'h10, '0, 1'b0, lat, p1, got);
      chk_line("data_valid_cleared", got, 512'h0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
